// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and helpers for the SPI daisy port
package spi_pkg;

    localparam int   SPI_SYNC_STAGES_DEFAULT = 2;
    localparam logic SCK_IDLE                = 1'b0;
    localparam logic CS_N_IDLE               = 1'b1;

    // Counter width able to hold the value w itself (0..w inclusive).
    function automatic int clog2p1(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage synchroniser with rise/fall detection
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            prev <= pipe[STAGES-1];
        end
    end

    assign level = pipe[STAGES-1];
    assign rise  = pipe[STAGES-1] & ~prev;
    assign fall  = ~pipe[STAGES-1] & prev;

endmodule

// File: rtl/spi_daisy_port.sv
// rtl/spi_daisy_port.sv - SPI mode-0 slave with daisy-chain passthrough and word strobes
module spi_daisy_port
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_n_in,
    output logic                  sdo_out,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_load_err,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_short,
    output logic                  busy
);

    localparam int CW = clog2p1(DATA_WIDTH);

    logic                   sck_level, sck_rise, sck_fall;
    logic                   cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_pipe;
    logic                   sdi_sync;
    logic [SYNC_STAGES-1:0] warm;
    logic                   primed;
    logic                   armed;
    logic                   active;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [CW-1:0]          bit_cnt;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sck_sync (
        .clk   (clk_in),
        .rst_n (reset_n_in),
        .din   (sck_in),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_N_IDLE)) u_cs_sync (
        .clk   (clk_in),
        .rst_n (reset_n_in),
        .din   (cs_n_in),
        .level (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_level, cs_fall};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sdi_pipe <= '0;
            warm     <= '0;
        end else begin
            sdi_pipe <= {sdi_pipe[SYNC_STAGES-2:0], sdi_in};
            warm     <= {warm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sdi_sync = sdi_pipe[SYNC_STAGES-1];
    // The cs_n synchroniser starts at its idle level; arming waits until the
    // reset value has been flushed so a frame already in progress stays ignored.
    assign primed   = warm[SYNC_STAGES-1];
    assign active   = ~cs_sync & armed;
    assign busy     = active;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            armed       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            sdo_out     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_short    <= 1'b0;
            tx_load_err <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            rx_short    <= 1'b0;
            tx_load_err <= 1'b0;
            armed       <= armed | (cs_sync & primed);

            if (cs_rise && armed) begin
                if (bit_cnt == CW'(DATA_WIDTH)) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else if (bit_cnt != '0) begin
                    rx_short <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (active && sck_rise) begin
                shreg <= {shreg[DATA_WIDTH-2:0], sdi_sync};
                if (bit_cnt != CW'(DATA_WIDTH)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            // A load never coincides with a shift: shifting requires an active frame.
            if (tx_load) begin
                if (active) begin
                    tx_load_err <= 1'b1;
                end else begin
                    shreg <= tx_data;
                end
            end

            if (!active || sck_fall) begin
                sdo_out <= shreg[DATA_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_spi_daisy_port.sv
// tb/tb_spi_daisy_port.sv - randomized scoreboard bench for spi_daisy_port (W=8)
module tb_spi_daisy_port;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sck = 1'b0;
    logic         sdi = 1'b0;
    logic         cs_n = 1'b1;
    logic         sdo;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0;
    logic         tx_load_err;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_short;
    logic         busy;

    spi_daisy_port #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_in      (clk),
        .reset_n_in  (rst_n),
        .sck_in      (sck),
        .sdi_in      (sdi),
        .cs_n_in     (cs_n),
        .sdo_out     (sdo),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_load_err (tx_load_err),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_short    (rx_short),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [W-1:0] data;
    } ev_t;

    localparam int EV_VALID = 1;
    localparam int EV_SHORT = 2;
    localparam int EV_ERR   = 3;

    ev_t  evq[$];
    logic sdo_q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_cs_cyc = 0;

    logic [W-1:0] m_shreg = '0;
    logic [W-1:0] m_rx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_event(input int kind, input logic [W-1:0] data);
        ev_t e;
        if (evq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
        end else begin
            e = evq.pop_front();
            check("event_kind", kind, e.kind);
            if (kind != EV_ERR) begin
                check("rx_data", data, e.data);
                check("strobe_latency", cyc - last_cs_cyc, 3);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)    pop_event(EV_VALID, rx_data);
            if (rx_short)    pop_event(EV_SHORT, rx_data);
            if (tx_load_err) pop_event(EV_ERR, '0);
        end
    end

    always @(posedge sck) begin
        if (sdo_q.size() > 0) check("sdo_bit", sdo, sdo_q.pop_front());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_idle(input logic [W-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        tick(2);
        m_shreg = v;
    endtask

    // Stream view: the device outputs its preloaded word MSB-first followed by
    // every received bit, and keeps the most recent W bits as its word.
    task automatic model_frame(input logic [31:0] data, input int n, input bit mid_load);
        logic stream[$];
        for (int k = W - 1; k >= 0; k--) stream.push_back(m_shreg[k]);
        for (int k = n - 1; k >= 0; k--) stream.push_back(data[k]);
        for (int k = 0; k < n; k++) sdo_q.push_back(stream[k]);
        for (int k = 0; k < W; k++) m_shreg[W-1-k] = stream[stream.size() - W + k];
        if (mid_load) evq.push_back('{EV_ERR, '0});
        if (n >= W) begin
            m_rx = m_shreg;
            evq.push_back('{EV_VALID, m_rx});
        end else if (n > 0) begin
            evq.push_back('{EV_SHORT, m_rx});
        end
    endtask

    task automatic drive_bits(input logic [31:0] data, input int n, input bit mid_load);
        for (int i = 0; i < n; i++) begin
            sdi = data[n-1-i];
            if (mid_load && i == 3) begin
                tx_data = $urandom;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(3);
            end else begin
                tick(4);
            end
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [31:0] data, input int n, input bit mid_load);
        model_frame(data, n, mid_load && n > 3);
        cs_n = 1'b0;
        tick(4);
        drive_bits(data, n, mid_load && n > 3);
        tick(4);
        cs_n = 1'b1;
        last_cs_cyc = cyc;
        tick(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset_rx_data", rx_data, 0);
        check("reset_strobes", {rx_valid, rx_short, tx_load_err}, 0);
        check("reset_busy", busy, 0);
        check("reset_sdo", sdo, 0);
        rst_n = 1'b1;
        tick(6);

        do_frame(32'hA5, 8, 1'b0);
        load_idle(8'h3C);
        do_frame(32'hFF, 8, 1'b0);
        load_idle(8'h00);
        do_frame(32'h1234, 16, 1'b0);
        do_frame(32'h15, 5, 1'b0);
        do_frame(32'h0, 0, 1'b0);
        do_frame(32'hC3, 8, 1'b1);

        // Reset in mid-frame, then a frame already under way at release is ignored.
        cs_n = 1'b0;
        tick(4);
        drive_bits(32'hF, 4, 1'b0);
        rst_n = 1'b0;
        tick(2);
        m_shreg = '0;
        m_rx = '0;
        check("midreset_rx_data", rx_data, 0);
        check("midreset_busy", busy, 0);
        rst_n = 1'b1;
        tick(4);
        check("ignored_busy", busy, 0);
        drive_bits(32'hB7, 8, 1'b0);
        tick(4);
        cs_n = 1'b1;
        last_cs_cyc = cyc;
        tick(8);
        do_frame(32'h5A, 8, 1'b0);

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 2) == 0) load_idle(W'($urandom));
            do_frame($urandom, $urandom_range(0, 20), $urandom_range(0, 3) == 0);
        end

        tick(20);
        check("events_drained", evq.size(), 0);
        check("sdo_drained", sdo_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
